// File: rtl/cdp_mul_rcv_pkg.sv
// Shared widths and saturation helpers for the CDP multiplier-result receiver.
package cdp_mul_rcv_pkg;

    localparam int IN_BW_DEF  = 25;
    localparam int ACC_BW_DEF = 32;
    localparam int OUT_BW_DEF = 16;
    localparam int GRP_W_DEF  = 4;
    localparam int SHIFT_W    = 5;
    localparam int FIFO_DEPTH = 2;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/cdp_dp_mul_rcv_fifo2.sv
// Two-entry register FIFO with occupancy count and a valid/ready pop side.
module cdp_dp_mul_rcv_fifo2
    import cdp_mul_rcv_pkg::*;
#(
    parameter int pW = 17
) (
    input  logic          autosa_core_clk,
    input  logic          autosa_core_rstn,
    input  logic          i_push,
    input  logic [pW-1:0] i_push_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [1:0]    o_count,
    output logic          o_vld,
    input  logic          i_rdy,
    output logic [pW-1:0] o_data
);

    logic [pW-1:0] r_mem [FIFO_DEPTH];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == 2'(FIFO_DEPTH));
    assign o_empty = (r_count == 2'd0);
    assign o_vld   = ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = o_vld & i_rdy;
    assign w_push  = i_push & ~o_full;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/cdp_dp_mul_acc_rcv.sv
// Group accumulator for the CDP multiplier product stream: sum, round-shift, saturate, buffer.
// Optional CDP_MUL_RCV_PERF_EN adds saturation and input-stall performance counters.
module cdp_dp_mul_acc_rcv
    import cdp_mul_rcv_pkg::*;
#(
    parameter int pIN_BW  = IN_BW_DEF,
    parameter int pACC_BW = ACC_BW_DEF,
    parameter int pOUT_BW = OUT_BW_DEF,
    parameter int pGRP_W  = GRP_W_DEF
) (
    input  logic                      autosa_core_clk,
    input  logic                      autosa_core_rstn,
    input  logic                      mul_unit_vld,
    output logic                      mul_unit_rdy,
    input  logic signed [pIN_BW-1:0]  mul_unit_pd,
    input  logic [pGRP_W-1:0]         cfg_grp_len,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    output logic                      acc_out_vld,
    input  logic                      acc_out_rdy,
    output logic signed [pOUT_BW-1:0] acc_out_pd,
`ifdef CDP_MUL_RCV_PERF_EN
    output logic [31:0]               perf_sat_cnt,
    output logic [31:0]               perf_stall_cnt,
`endif
    output logic                      acc_out_sat
);

    localparam logic signed [pACC_BW:0] LIM_MAX = (pACC_BW+1)'(sat_max(pOUT_BW));
    localparam logic signed [pACC_BW:0] LIM_MIN = (pACC_BW+1)'(sat_min(pOUT_BW));

    // Returns {sat, result}; the extra bit keeps the rounding add from overflowing.
    function automatic logic [pOUT_BW:0] round_sat(input logic signed [pACC_BW-1:0] sum,
                                                   input logic [SHIFT_W-1:0]        sh);
        logic signed [pACC_BW:0] ext;
        logic signed [pACC_BW:0] rnd;
        logic signed [pACC_BW:0] res;
        ext = {sum[pACC_BW-1], sum};
        rnd = ext;
        if (sh != '0) begin
            rnd = ext + ((pACC_BW+1)'(1) << (sh - SHIFT_W'(1)));
        end
        res = rnd >>> sh;
        if (res > LIM_MAX) begin
            return {1'b1, LIM_MAX[pOUT_BW-1:0]};
        end else if (res < LIM_MIN) begin
            return {1'b1, LIM_MIN[pOUT_BW-1:0]};
        end
        return {1'b0, res[pOUT_BW-1:0]};
    endfunction

    logic signed [pACC_BW-1:0] r_acc;
    logic [pGRP_W-1:0]         r_cnt;
    logic [pGRP_W-1:0]         r_grp_len;
    logic [SHIFT_W-1:0]        r_shift;

    logic                      w_accept;
    logic                      w_first;
    logic                      w_last;
    logic [pGRP_W-1:0]         w_grp_len_eff;
    logic [SHIFT_W-1:0]        w_shift_eff;
    logic signed [pACC_BW-1:0] w_pd_ext;
    logic signed [pACC_BW-1:0] w_sum;
    logic [pOUT_BW:0]          w_post;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    logic [1:0]                w_count;
    logic [pOUT_BW:0]          w_head;

    // The first beat of a group uses live config; later beats use the copy latched then.
    assign w_first       = (r_cnt == '0);
    assign w_grp_len_eff = w_first ? cfg_grp_len : r_grp_len;
    assign w_shift_eff   = w_first ? cfg_shift : r_shift;

    assign mul_unit_rdy  = ~w_full;
    assign w_accept      = mul_unit_vld & mul_unit_rdy;
    assign w_last        = (r_cnt == w_grp_len_eff);
    assign w_pd_ext      = pACC_BW'(mul_unit_pd);
    assign w_sum         = r_acc + w_pd_ext;
    assign w_post        = round_sat(w_sum, w_shift_eff);
    assign w_push        = w_accept & w_last;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_grp_len <= '0;
            r_shift   <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_grp_len <= cfg_grp_len;
                r_shift   <= cfg_shift;
            end
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + pGRP_W'(1);
            end
        end
    end

    cdp_dp_mul_rcv_fifo2 #(
        .pW (pOUT_BW + 1)
    ) u_fifo (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .i_push           (w_push),
        .i_push_data      (w_post),
        .o_full           (w_full),
        .o_empty          (w_empty),
        .o_count          (w_count),
        .o_vld            (acc_out_vld),
        .i_rdy            (acc_out_rdy),
        .o_data           (w_head)
    );

    assign acc_out_sat = w_head[pOUT_BW];
    assign acc_out_pd  = w_head[pOUT_BW-1:0];

`ifdef CDP_MUL_RCV_PERF_EN
    logic [31:0] r_perf_sat;
    logic [31:0] r_perf_stall;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            r_perf_sat   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push && w_post[pOUT_BW] && (r_perf_sat != '1)) begin
                r_perf_sat <= r_perf_sat + 32'd1;
            end
            if (mul_unit_vld && !mul_unit_rdy && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_sat_cnt   = r_perf_sat;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_cdp_dp_mul_acc_rcv.sv
// Randomised scoreboard bench for cdp_dp_mul_acc_rcv against an arithmetic group-sum model.
module tb_cdp_dp_mul_acc_rcv;

    logic               clk;
    logic               rstn;
    logic               mul_vld;
    logic               mul_rdy;
    logic signed [24:0] mul_pd;
    logic [3:0]         cfg_grp_len;
    logic [4:0]         cfg_shift;
    logic               out_vld;
    logic               out_rdy;
    logic signed [15:0] out_pd;
    logic               out_sat;
`ifdef CDP_MUL_RCV_PERF_EN
    logic [31:0]        perf_sat_cnt;
    logic [31:0]        perf_stall_cnt;
`endif

    typedef struct {
        longint pd;
        bit     sat;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint m_acc = 0;
    int     m_cnt = 0;
    int     m_gl  = 0;
    int     m_sh  = 0;
    longint m_sat_cnt = 0;
    longint m_stall_cnt = 0;
    bit     rnd_done;

    cdp_dp_mul_acc_rcv dut (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .mul_unit_vld     (mul_vld),
        .mul_unit_rdy     (mul_rdy),
        .mul_unit_pd      (mul_pd),
        .cfg_grp_len      (cfg_grp_len),
        .cfg_shift        (cfg_shift),
        .acc_out_vld      (out_vld),
        .acc_out_rdy      (out_rdy),
        .acc_out_pd       (out_pd),
`ifdef CDP_MUL_RCV_PERF_EN
        .perf_sat_cnt     (perf_sat_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
`endif
        .acc_out_sat      (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer group sum, 32-bit wrap, round-half-up shift, clamp to 16 bits.
    always @(negedge clk) begin
        #2;
        if (!rstn) begin
            m_acc = 0;
            m_cnt = 0;
            q.delete();
        end else begin
            if (mul_vld && !mul_rdy) m_stall_cnt++;
            if (mul_vld && mul_rdy) begin
                if (m_cnt == 0) begin
                    m_gl = int'(cfg_grp_len);
                    m_sh = int'(cfg_shift);
                end
                m_acc = longint'(int'(m_acc + longint'(mul_pd)));
                if (m_cnt == m_gl) begin
                    exp_t   e;
                    longint r;
                    r = m_acc;
                    if (m_sh > 0) r = (m_acc + (longint'(1) <<< (m_sh - 1))) >>> m_sh;
                    e.sat = 1'b0;
                    if (r > 32767) begin r = 32767; e.sat = 1'b1; end
                    if (r < -32768) begin r = -32768; e.sat = 1'b1; end
                    e.pd = r;
                    if (e.sat) m_sat_cnt++;
                    q.push_back(e);
                    m_acc = 0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: every queued entry corresponds to one FIFO slot, so occupancy drives vld/rdy.
    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_vld", longint'(out_vld), 0);
            check("rst_rdy", longint'(mul_rdy), 1);
            check("rst_pd", longint'(out_pd), 0);
            check("rst_sat", longint'(out_sat), 0);
        end else begin
            check("out_vld", longint'(out_vld), (q.size() != 0) ? 1 : 0);
            check("mul_rdy", longint'(mul_rdy), (q.size() != 2) ? 1 : 0);
            if (out_vld && q.size() != 0) begin
                check("out_pd", longint'(out_pd), q[0].pd);
                check("out_sat", longint'(out_sat), longint'(q[0].sat));
                if (out_rdy) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint v);
        bit taken;
        taken = 1'b0;
        mul_vld = 1'b1;
        mul_pd  = 25'(v);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            taken = mul_rdy;
            step();
            if (taken) break;
        end
        if (!taken) begin
            errors++;
            $display("FAIL send_timeout: got rdy 0 expected 1 at %0t", $time);
        end
        mul_vld = 1'b0;
    endtask

    function automatic longint rand_pd();
        case ($urandom_range(0, 4))
            0:       return 16777215;
            1:       return -16777216;
            2:       return longint'($urandom_range(0, 200)) - 100;
            default: return longint'(signed'(25'($urandom)));
        endcase
    endfunction

    initial begin
        rstn        = 1'b0;
        mul_vld     = 1'b0;
        mul_pd      = '0;
        cfg_grp_len = '0;
        cfg_shift   = '0;
        out_rdy     = 1'b1;
        rnd_done    = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        step();

        cfg_grp_len = 4'd3;
        cfg_shift   = 5'd2;
        send(10); send(20); send(30); send(41);

        cfg_grp_len = 4'd0;
        cfg_shift   = 5'd1;
        send(-5); send(3);

        cfg_shift = 5'd0;
        send(16777215); send(-16777216);
        repeat (3) step();

        out_rdy = 1'b0;
        fork
            begin send(1); send(2); send(3); end
            begin repeat (8) step(); out_rdy = 1'b1; end
        join
        repeat (3) step();

        cfg_grp_len = 4'd2;
        cfg_shift   = 5'd0;
        send(5); send(6);
        cfg_grp_len = 4'd0;
        send(7);
        send(100);
        cfg_grp_len = 4'd2;
        send(9);
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
        send(1); send(2); send(3);
        repeat (3) step();

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    cfg_grp_len = 4'($urandom_range(0, 15));
                    cfg_shift   = 5'($urandom_range(0, 31));
                    if ($urandom_range(0, 3) == 0) cfg_grp_len = 4'd0;
                    send(rand_pd());
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_rdy = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join

        out_rdy = 1'b1;
        repeat (20) step();
        check("drain_empty", longint'(q.size()), 0);
`ifdef CDP_MUL_RCV_PERF_EN
        check("perf_sat_cnt", longint'(perf_sat_cnt), m_sat_cnt);
        check("perf_stall_cnt", longint'(perf_stall_cnt), m_stall_cnt);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdp_dp_mul_acc_rcv.md
Name: cdp_dp_mul_acc_rcv

Overview:
Receiving end of the CDP datapath multiplier result interface (mul_unit_vld/mul_unit_rdy/mul_unit_pd).
- Accepts the signed product stream and sums each group of (cfg_grp_len+1) consecutive products.
- Scales each group sum by an arithmetic right shift with rounding, saturates it to the output width, and buffers results in a 2-entry output FIFO.
- Sits between the multiplier unit and the CDP output/normalisation stage.

Parameters:
pIN_BW, 25, signed product width (multiplier pINA_BW+pINB_BW)
pACC_BW, 32, signed accumulator width (>= pIN_BW)
pOUT_BW, 16, signed output width (< pACC_BW)
pGRP_W, 4, group-length field width

Ports:
autosa_core_clk  in  1  clock
autosa_core_rstn  in  1  reset
mul_unit_vld  in  1  product valid
mul_unit_rdy  out  1  product ready
mul_unit_pd  in  pIN_BW  signed product
cfg_grp_len  in  pGRP_W  products per group minus 1
cfg_shift  in  5  right-shift amount, 0..pACC_BW-1
acc_out_vld  out  1  result valid
acc_out_rdy  in  1  result ready
acc_out_pd  out  pOUT_BW  signed scaled, saturated result
acc_out_sat  out  1  result was saturated

Behaviour:
- Reset and clock (already decided): reset autosa_core_rstn, asynchronous, active-low; clock autosa_core_clk.
- Reset values: acc=0, cnt=0, FIFO empty, acc_out_vld=0, acc_out_pd=0, acc_out_sat=0.
  - mul_unit_rdy=1 whenever the FIFO is not full, including during reset.
- Accept on mul_unit_vld & mul_unit_rdy.
  - mul_unit_rdy = (fifo_count != 2).
  - No combinational path from acc_out_rdy to mul_unit_rdy: full FIFO with same-cycle pop still holds rdy low.
- Config sampling: cfg_grp_len and cfg_shift are captured on the first beat of a group (cnt==0).
  - That first beat uses the live values.
  - Later beats use the latched values; mid-group config changes are ignored.
- Accumulate: sum = acc + sext(mul_unit_pd) to pACC_BW, two's-complement wrap (no accumulator saturation).
- Non-last beat: acc<=sum, cnt<=cnt+1.
- Last beat (cnt==grp_len_eff): acc<=0, cnt<=0; sum is post-processed and pushed into the FIFO on the same edge.
- Post-process:
  - If shift>0: r = (sum + 2^(shift-1)) >>> shift, computed at pACC_BW+1 bits so the rounding add cannot overflow.
  - If shift=0: r = sum.
  - r is clamped to [-2^(pOUT_BW-1), 2^(pOUT_BW-1)-1]; sat=1 iff clamped.
- Latency: result visible on acc_out_vld the cycle after the last beat is accepted.
- Output: FIFO head drives acc_out_pd and acc_out_sat; pop on acc_out_vld & acc_out_rdy.
  - Outputs are stable while vld=1 and rdy=0.
  - Simultaneous push and pop at count 1 keeps count 1, correctly ordered.
- grp_len=0: every accepted product yields one result.
- Reset mid-group discards the partial sum and all buffered results.

Optional Feature:
CDP_MUL_RCV_PERF_EN
- Defined: adds outputs perf_sat_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - perf_sat_cnt increments per pushed result with sat=1.
  - perf_stall_cnt increments each cycle with mul_unit_vld & ~mul_unit_rdy.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cdp_mul_rcv_pkg: default widths, SHIFT_W=5, FIFO_DEPTH=2, saturation limit constants as functions of pOUT_BW.
- Sub-module cdp_dp_mul_rcv_fifo2: 2-entry register FIFO with count, full/empty, valid/ready pop.
- Top module holds the accumulator, counter, config latch and round/saturate logic.

Test Plan:
- grp_len=3, shift=2, products 10,20,30,41 → one result 25 (101+2=103>>>2), sat=0, one cycle after 4th accept.
- grp_len=0, shift=1, product -5 → -2 (-5+1=-4>>>1); product 3 → 2.
- grp_len=0, shift=0, product 16777215 → 32767 sat=1; product -16777216 → -32768 sat=1.
- acc_out_rdy=0, grp_len=0, three products 1,2,3 → two results buffered, mul_unit_rdy=0, third held. Raise acc_out_rdy → outputs 1,2,3 in order, rdy returns after first pop.
- grp_len=2, after 2 beats change cfg_grp_len to 0 → group still closes on 3rd beat. Assert reset after 1 beat of a new group → no output, next group sums from 0.
- With CDP_MUL_RCV_PERF_EN defined: 2 saturated results plus 5 stall cycles → perf_sat_cnt=2, perf_stall_cnt=5.
